warp_issue_sched: RTL and testbench
===================================

Name: warp_issue_sched

Overview:
- In-order dual-issue scheduler that sits in front of the integer issue stage.
- Buffers one two-slot bundle and tracks register busy state in a scoreboard.
- Each cycle it decides which buffered slots issue, and steers each issuing slot to xarith0/1, xlogic0/1 or xshift.
- Its outputs drive the valid/select lanes that gate operand delivery to those pipelines; writeback ports retire scoreboard entries.

Parameters:
- REG_ADDR_W, 5, register index width; scoreboard depth is 2**REG_ADDR_W.
- STAT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_input_valid  in  1  incoming bundle valid
- o_input_ready  out  1  scheduler accepts the bundle this cycle
- i_slotN_class (N=0,1)  in  2  0=ARITH 1=LOGIC 2=SHIFT 3=NOP
- i_slotN_rd, i_slotN_rs1, i_slotN_rs2  in  REG_ADDR_W  register indices
- i_slotN_wen  in  1  slot writes rd
- i_flush  in  1  drop buffered, unissued slots
- i_wbM_valid, i_wbM_rd (M=0,1)  in  1, REG_ADDR_W  writeback retire ports
- o_xarith0_valid, o_xarith1_valid, o_xlogic0_valid, o_xlogic1_valid, o_xshift_valid  out  1  pipe receives an op this cycle
- o_xarith0_sel, o_xarith1_sel, o_xlogic0_sel, o_xlogic1_sel, o_xshift_sel  out  1  source buffer slot (0/1) for that pipe
- o_issue0, o_issue1  out  1  buffer slot issued this cycle
- o_busy  out  2**REG_ADDR_W  scoreboard snapshot

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous, active-low (i_rst_n).
- Reset values: the buffer goes to EMPTY and the scoreboard to all zeros. All outputs are therefore 0, except o_input_ready=1. Reset applied mid-operation discards everything, including partially issued bundles.
- FSM on the buffer has three states:
  - EMPTY: no bundle held.
  - FULL: both slots pending.
  - PART: slot0 has issued, slot1 is pending.
- FSM transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY if both issue, otherwise →PART if only slot0 issues.
  - PART→EMPTY when slot1 issues.
  - Any state with i_flush→EMPTY. Flush has priority over accept in the same cycle; no accept that cycle.
- Handshake: o_input_ready = EMPTY, or (all pending slots issue this cycle and !i_flush). A bundle is accepted when valid&&ready and is captured into the buffer.
- Issue timing: earliest issue is the cycle after accept. Issue outputs are combinational from buffer state and the registered scoreboard.
- Per-slot issue condition:
  - Hazards: no issue if rs1 or rs2 is busy (RAW), or if wen and rd is busy (WAW). Register 0 is never busy and is never marked busy.
  - NOP: has no pipe or hazard requirement; it issues once in-order permits.
  - Scoreboard bypass: there is none. A writeback in cycle C unblocks issue in C+1.
- Slot1 additional requirements:
  - Slot0 issues this cycle or is already issued (PART).
  - If both issue together, slot1 must not read slot0's rd (slot0 wen, rd≠0). Otherwise slot1 stalls one cycle.
  - Structural hazards:
    - If both slots are SHIFT, slot1 stalls.
    - If both are ARITH, slot0 goes to xarith0 and slot1 to xarith1. LOGIC follows the same rule.
    - A lone ARITH/LOGIC op uses pipe 0.
- Scoreboard updates:
  - An issuing slot with wen sets busy[rd].
  - i_wbM_valid clears busy[i_wbM_rd].
  - If set and clear hit the same reg in the same cycle, set wins.
  - Flush does not touch the scoreboard.

Optional Feature:
- Macro: WARP_ISSUE_STATS_EN.
- When defined, the block adds these outputs, all STAT_W wide and wrapping modulo 2**STAT_W:
  - o_stat_issued: number of slots issued.
  - o_stat_raw_stall: cycles in which a pending slot is blocked by RAW/WAW.
  - o_stat_struct_stall: cycles in which slot1 is blocked by the shift conflict or the intra-bundle dependency.
- All counters reset to 0.
- When undefined, these ports and counters do not exist.

Decomposition:
- Shared package/defines: class encodings (CLASS_ARITH/LOGIC/SHIFT/NOP) and FSM state encodings, alongside the existing bundle defines.
- Sub-module: warp_scoreboard (busy vector, set port, two clear ports, set-wins rule, x0 masking).

Test Plan:
- Bundle {ARITH rd=3 rs=1,2; LOGIC rd=4 rs=5,6}, empty scoreboard → cycle+1: o_xarith0_valid=1 sel=0, o_xlogic0_valid=1 sel=1, o_issue0=o_issue1=1, busy[3]=busy[4]=1 next cycle.
- Bundle {SHIFT rd=7; SHIFT rd=8} → first issue cycle: only o_xshift_valid sel=0 (FSM→PART); following cycle: o_xshift_valid sel=1, FSM→EMPTY.
- busy[5]=1, bundle slot0 reads rs1=5 → no issue and o_input_ready=0; pulse i_wb0_valid rd=5 in cycle C → slot0 issues in C+1.
- Intra-bundle dependency {ARITH rd=9; ARITH rs1=9} → slot0 issues alone; slot1 then waits on busy[9] until writeback of 9.
- Same-cycle issue setting rd=10 and i_wb1 clearing rd=10 → busy[10]=1 afterward; a write to rd=0 never sets busy[0].
- i_flush in PART with i_input_valid=1 → o_input_ready=0, FSM→EMPTY, scoreboard unchanged; next cycle ready=1 and the new bundle is accepted.

Source files
------------

// File: rtl/warp_issue_sched_pkg.sv
// Shared encodings for the warp issue scheduler: instruction classes, buffer
// FSM states and bundle-level helpers.
package warp_issue_sched_pkg;

  localparam int NUM_SLOTS = 2;

  typedef enum logic [1:0] {
    CLASS_ARITH = 2'd0,
    CLASS_LOGIC = 2'd1,
    CLASS_SHIFT = 2'd2,
    CLASS_NOP   = 2'd3
  } class_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_PART  = 2'd2
  } state_e;

  // A NOP never produces a result, whatever its wen bit says.
  function automatic logic is_writer(input class_e cls, input logic wen);
    return wen && (cls != CLASS_NOP);
  endfunction

endpackage

// File: rtl/warp_issue_sched_if.sv
// Bundle, flush, writeback and pipe-select lanes of the warp issue scheduler.
// The scheduler connects through the slave modport, its driver through master.
interface warp_issue_sched_if #(
  parameter int REG_ADDR_W = 5
);
  logic                       i_input_valid;
  logic                       o_input_ready;
  logic [1:0]                 i_slot0_class, i_slot1_class;
  logic [REG_ADDR_W-1:0]      i_slot0_rd, i_slot0_rs1, i_slot0_rs2;
  logic [REG_ADDR_W-1:0]      i_slot1_rd, i_slot1_rs1, i_slot1_rs2;
  logic                       i_slot0_wen, i_slot1_wen;
  logic                       i_flush;
  logic                       i_wb0_valid, i_wb1_valid;
  logic [REG_ADDR_W-1:0]      i_wb0_rd, i_wb1_rd;
  logic                       o_xarith0_valid, o_xarith1_valid, o_xlogic0_valid;
  logic                       o_xlogic1_valid, o_xshift_valid;
  logic                       o_xarith0_sel, o_xarith1_sel, o_xlogic0_sel;
  logic                       o_xlogic1_sel, o_xshift_sel;
  logic                       o_issue0, o_issue1;
  logic [2**REG_ADDR_W-1:0]   o_busy;

  modport master (
    output i_input_valid, i_slot0_class, i_slot1_class,
           i_slot0_rd, i_slot0_rs1, i_slot0_rs2, i_slot1_rd, i_slot1_rs1, i_slot1_rs2,
           i_slot0_wen, i_slot1_wen, i_flush, i_wb0_valid, i_wb1_valid, i_wb0_rd, i_wb1_rd,
    input  o_input_ready, o_xarith0_valid, o_xarith1_valid, o_xlogic0_valid,
           o_xlogic1_valid, o_xshift_valid, o_xarith0_sel, o_xarith1_sel, o_xlogic0_sel,
           o_xlogic1_sel, o_xshift_sel, o_issue0, o_issue1, o_busy
  );

  modport slave (
    input  i_input_valid, i_slot0_class, i_slot1_class,
           i_slot0_rd, i_slot0_rs1, i_slot0_rs2, i_slot1_rd, i_slot1_rs1, i_slot1_rs2,
           i_slot0_wen, i_slot1_wen, i_flush, i_wb0_valid, i_wb1_valid, i_wb0_rd, i_wb1_rd,
    output o_input_ready, o_xarith0_valid, o_xarith1_valid, o_xlogic0_valid,
           o_xlogic1_valid, o_xshift_valid, o_xarith0_sel, o_xarith1_sel, o_xlogic0_sel,
           o_xlogic1_sel, o_xshift_sel, o_issue0, o_issue1, o_busy
  );
endinterface

// File: rtl/warp_scoreboard.sv
// Register busy vector: one set mask from issue, two writeback clear ports.
// A set beats a clear of the same register; register 0 is never busy.
module warp_scoreboard
  import warp_issue_sched_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [2**REG_ADDR_W-1:0]  i_set_mask,
  input  logic                      i_clr0_valid,
  input  logic [REG_ADDR_W-1:0]     i_clr0_idx,
  input  logic                      i_clr1_valid,
  input  logic [REG_ADDR_W-1:0]     i_clr1_idx,
  output logic [2**REG_ADDR_W-1:0]  o_busy
);
  localparam int NREG = 2**REG_ADDR_W;
  localparam logic [NREG-1:0] ONE = NREG'(1);

  logic [NREG-1:0] busy_q, busy_d, clr_mask_s, merged_s;

  assign clr_mask_s = ({NREG{i_clr0_valid}} & (ONE << i_clr0_idx)) |
                      ({NREG{i_clr1_valid}} & (ONE << i_clr1_idx));
  assign merged_s   = (busy_q & ~clr_mask_s) | i_set_mask;
  assign busy_d     = {merged_s[NREG-1:1], 1'b0};
  assign o_busy     = busy_q;

  // Busy vector register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/warp_issue_sched.sv
// In-order dual-issue scheduler: one buffered two-slot bundle, scoreboard
// hazard checks and pipe steering. Define WARP_ISSUE_STATS_EN for counters.
module warp_issue_sched
  import warp_issue_sched_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  warp_issue_sched_if.slave bus
`ifdef WARP_ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0] o_stat_issued,
  output logic [STAT_W-1:0] o_stat_raw_stall,
  output logic [STAT_W-1:0] o_stat_struct_stall
`endif
);
  localparam int NREG = 2**REG_ADDR_W;
  localparam logic [NREG-1:0] ONE = NREG'(1);

  state_e                                state_q;
  class_e                                cls_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0][REG_ADDR_W-1:0]  rd_q, rs1_q, rs2_q;
  logic [NUM_SLOTS-1:0]                  wen_q;

  logic [NREG-1:0] busy_s, set_mask_s;
  logic [1:0]      hz_s;
  logic            dep_s, shconf_s, issue0_s, issue1_s, ready_s, accept_s, pair_s;

  // Per-slot RAW/WAW check against the registered scoreboard.
  always_comb begin
    hz_s = 2'b00;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      hz_s[s] = (cls_q[s] != CLASS_NOP) &&
                (busy_s[rs1_q[s]] || busy_s[rs2_q[s]] || (wen_q[s] && busy_s[rd_q[s]]));
    end
  end

  assign dep_s    = is_writer(cls_q[0], wen_q[0]) && (rd_q[0] != '0) && (cls_q[1] != CLASS_NOP) &&
                    ((rs1_q[1] == rd_q[0]) || (rs2_q[1] == rd_q[0]));
  assign shconf_s = (cls_q[0] == CLASS_SHIFT) && (cls_q[1] == CLASS_SHIFT);
  assign issue0_s = (state_q == ST_FULL) && !bus.i_flush && !hz_s[0];
  assign issue1_s = !bus.i_flush && !hz_s[1] &&
                    ((state_q == ST_PART) || (issue0_s && !dep_s && !shconf_s));
  assign ready_s  = !bus.i_flush && ((state_q == ST_EMPTY) ||
                    ((state_q == ST_FULL) && issue0_s && issue1_s) ||
                    ((state_q == ST_PART) && issue1_s));
  assign accept_s = bus.i_input_valid && ready_s;

  // Slot1 takes the second pipe of a class only when slot0 holds the first.
  assign pair_s = issue0_s && (cls_q[0] == cls_q[1]);

  assign bus.o_xarith0_valid = (issue0_s && cls_q[0] == CLASS_ARITH) ||
                               (issue1_s && cls_q[1] == CLASS_ARITH && !pair_s);
  assign bus.o_xarith0_sel   = issue1_s && cls_q[1] == CLASS_ARITH && !pair_s;
  assign bus.o_xarith1_valid = issue1_s && cls_q[1] == CLASS_ARITH && pair_s;
  assign bus.o_xarith1_sel   = bus.o_xarith1_valid;
  assign bus.o_xlogic0_valid = (issue0_s && cls_q[0] == CLASS_LOGIC) ||
                               (issue1_s && cls_q[1] == CLASS_LOGIC && !pair_s);
  assign bus.o_xlogic0_sel   = issue1_s && cls_q[1] == CLASS_LOGIC && !pair_s;
  assign bus.o_xlogic1_valid = issue1_s && cls_q[1] == CLASS_LOGIC && pair_s;
  assign bus.o_xlogic1_sel   = bus.o_xlogic1_valid;
  assign bus.o_xshift_valid  = (issue0_s && cls_q[0] == CLASS_SHIFT) ||
                               (issue1_s && cls_q[1] == CLASS_SHIFT);
  assign bus.o_xshift_sel    = issue1_s && cls_q[1] == CLASS_SHIFT;
  assign bus.o_issue0        = issue0_s;
  assign bus.o_issue1        = issue1_s;
  assign bus.o_input_ready   = ready_s;
  assign bus.o_busy          = busy_s;

  assign set_mask_s = ({NREG{issue0_s && is_writer(cls_q[0], wen_q[0])}} & (ONE << rd_q[0])) |
                      ({NREG{issue1_s && is_writer(cls_q[1], wen_q[1])}} & (ONE << rd_q[1]));

  warp_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_set_mask   (set_mask_s),
    .i_clr0_valid (bus.i_wb0_valid),
    .i_clr0_idx   (bus.i_wb0_rd),
    .i_clr1_valid (bus.i_wb1_valid),
    .i_clr1_idx   (bus.i_wb1_rd),
    .o_busy       (busy_s)
  );

  // Buffer FSM: flush beats everything, an accept can refill a draining bundle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
    end else if (bus.i_flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept_s) state_q <= ST_FULL;
        ST_FULL: begin
          if (issue0_s && issue1_s) state_q <= accept_s ? ST_FULL : ST_EMPTY;
          else if (issue0_s)        state_q <= ST_PART;
        end
        ST_PART:  if (issue1_s) state_q <= accept_s ? ST_FULL : ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  // Bundle capture on accept.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      cls_q[0] <= class_e'(bus.i_slot0_class);
      cls_q[1] <= class_e'(bus.i_slot1_class);
      rd_q     <= {bus.i_slot1_rd,  bus.i_slot0_rd};
      rs1_q    <= {bus.i_slot1_rs1, bus.i_slot0_rs1};
      rs2_q    <= {bus.i_slot1_rs2, bus.i_slot0_rs2};
      wen_q    <= {bus.i_slot1_wen, bus.i_slot0_wen};
    end
  end

`ifdef WARP_ISSUE_STATS_EN
  logic raw_stall_s, struct_stall_s;
  assign raw_stall_s    = !bus.i_flush && (((state_q == ST_FULL) && (hz_s != 2'b00)) ||
                                           ((state_q == ST_PART) && hz_s[1]));
  assign struct_stall_s = !bus.i_flush && (state_q == ST_FULL) && issue0_s && (dep_s || shconf_s);

  // Performance counters, wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stat_issued       <= '0;
      o_stat_raw_stall    <= '0;
      o_stat_struct_stall <= '0;
    end else begin
      o_stat_issued       <= o_stat_issued + STAT_W'(issue0_s) + STAT_W'(issue1_s);
      o_stat_raw_stall    <= o_stat_raw_stall + STAT_W'(raw_stall_s);
      o_stat_struct_stall <= o_stat_struct_stall + STAT_W'(struct_stall_s);
    end
  end
`endif
endmodule

// File: tb/tb_warp_issue_sched.sv
// Self-checking bench for warp_issue_sched: directed scenarios pinned by literal
// expectations, then randomized traffic against a slot-list reference model.
module tb_warp_issue_sched;
  import warp_issue_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  warp_issue_sched_if #(.REG_ADDR_W(5)) bus ();

`ifdef WARP_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_raw, stat_struct;
`endif

  warp_issue_sched #(.REG_ADDR_W(5), .STAT_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef WARP_ISSUE_STATS_EN
    ,
    .o_stat_issued       (stat_issued),
    .o_stat_raw_stall    (stat_raw),
    .o_stat_struct_stall (stat_struct)
`endif
  );

  // Reference model: list of pending slots plus a busy bitmap.
  bit        m_pend [2];
  int        m_cls  [2];
  int        m_rd [2], m_rs1 [2], m_rs2 [2];
  bit        m_wen  [2];
  bit [31:0] m_busy;
  int        m_issued;
  int        total = 0;
  int        bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int s, input int cls, input int rd, input int rs1, input int rs2, input bit wen);
    if (s == 0) begin
      bus.i_slot0_class = 2'(cls); bus.i_slot0_rd = 5'(rd);
      bus.i_slot0_rs1 = 5'(rs1);   bus.i_slot0_rs2 = 5'(rs2); bus.i_slot0_wen = wen;
    end else begin
      bus.i_slot1_class = 2'(cls); bus.i_slot1_rd = 5'(rd);
      bus.i_slot1_rs1 = 5'(rs1);   bus.i_slot1_rs2 = 5'(rs2); bus.i_slot1_wen = wen;
    end
  endtask

  task automatic idle();
    bus.i_input_valid = 1'b0; bus.i_flush = 1'b0;
    bus.i_wb0_valid = 1'b0;   bus.i_wb0_rd = 5'd0;
    bus.i_wb1_valid = 1'b0;   bus.i_wb1_rd = 5'd0;
    set_slot(0, 3, 0, 0, 0, 1'b0);
    set_slot(1, 3, 0, 0, 0, 1'b0);
  endtask

  // One cycle: derive expectations from the model, compare, then advance the model.
  task automatic step();
    bit        iss [2];
    bit        stop, ok, ready, accept;
    bit [4:0]  pv, ps;
    bit [31:0] nb;
    int        in_cls [2], in_rd [2], in_rs1 [2], in_rs2 [2];
    bit        in_wen [2];
    #1;
    if (!rst_n) begin
      @(posedge clk);
      m_pend = '{0, 0}; m_busy = '0; m_issued = 0;
      #1;
      return;
    end
    iss = '{0, 0}; stop = 0; pv = '0; ps = '0;
    if (!bus.i_flush) begin
      for (int s = 0; s < 2; s++) begin
        if (m_pend[s] && !stop) begin
          ok = (m_cls[s] == 3) ||
               !(m_busy[m_rs1[s]] || m_busy[m_rs2[s]] || (m_wen[s] && m_busy[m_rd[s]]));
          if (s == 1 && m_pend[0]) begin
            if (m_cls[0] == 2 && m_cls[1] == 2) ok = 0;
            if (m_cls[0] != 3 && m_wen[0] && m_rd[0] != 0 && m_cls[1] != 3 &&
                (m_rs1[1] == m_rd[0] || m_rs2[1] == m_rd[0])) ok = 0;
          end
          if (ok) iss[s] = 1; else stop = 1;
        end
      end
    end
    // pipe index: 0 xarith0, 1 xarith1, 2 xlogic0, 3 xlogic1, 4 xshift; first free wins
    for (int s = 0; s < 2; s++) begin
      if (iss[s]) begin
        case (m_cls[s])
          0, 1: begin
            if (!pv[2*m_cls[s]]) begin pv[2*m_cls[s]] = 1; ps[2*m_cls[s]] = 1'(s); end
            else begin pv[2*m_cls[s]+1] = 1; ps[2*m_cls[s]+1] = 1'(s); end
          end
          2: begin pv[4] = 1; ps[4] = 1'(s); end
          default: ;
        endcase
      end
    end
    ready = !bus.i_flush && ((!m_pend[0] || iss[0]) && (!m_pend[1] || iss[1]));
    accept = bus.i_input_valid && ready;

    chk("ready",  bus.o_input_ready, ready);
    chk("issue",  {bus.o_issue1, bus.o_issue0}, {iss[1], iss[0]});
    chk("pipe_valid", {bus.o_xshift_valid, bus.o_xlogic1_valid, bus.o_xlogic0_valid,
                       bus.o_xarith1_valid, bus.o_xarith0_valid}, pv);
    chk("pipe_sel", {bus.o_xshift_sel, bus.o_xlogic1_sel, bus.o_xlogic0_sel,
                     bus.o_xarith1_sel, bus.o_xarith0_sel}, ps);
    chk("busy", bus.o_busy, m_busy);

    nb = m_busy;
    if (bus.i_wb0_valid) nb[bus.i_wb0_rd] = 1'b0;
    if (bus.i_wb1_valid) nb[bus.i_wb1_rd] = 1'b0;
    for (int s = 0; s < 2; s++) if (iss[s] && m_wen[s] && m_cls[s] != 3) nb[m_rd[s]] = 1'b1;
    nb[0] = 1'b0;
    in_cls = '{int'(bus.i_slot0_class), int'(bus.i_slot1_class)};
    in_rd  = '{int'(bus.i_slot0_rd),  int'(bus.i_slot1_rd)};
    in_rs1 = '{int'(bus.i_slot0_rs1), int'(bus.i_slot1_rs1)};
    in_rs2 = '{int'(bus.i_slot0_rs2), int'(bus.i_slot1_rs2)};
    in_wen = '{bus.i_slot0_wen, bus.i_slot1_wen};

    @(posedge clk);
    m_busy = nb;
    m_issued += int'(iss[0]) + int'(iss[1]);
    for (int s = 0; s < 2; s++) begin
      if (bus.i_flush || iss[s]) m_pend[s] = 0;
      if (accept) begin
        m_pend[s] = 1; m_cls[s] = in_cls[s]; m_rd[s] = in_rd[s];
        m_rs1[s] = in_rs1[s]; m_rs2[s] = in_rs2[s]; m_wen[s] = in_wen[s];
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle();
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", bus.o_input_ready, 1);
    chk("rst_busy",  bus.o_busy, 0);
    chk("rst_issue", {bus.o_issue1, bus.o_issue0, bus.o_xarith0_valid, bus.o_xshift_valid}, 0);
  endtask

  initial begin
    m_pend = '{0, 0}; m_busy = '0; m_issued = 0;
    do_reset();

    // ARITH + LOGIC dual issue
    set_slot(0, 0, 3, 1, 2, 1'b1); set_slot(1, 1, 4, 5, 6, 1'b1);
    bus.i_input_valid = 1'b1; step();
    bus.i_input_valid = 1'b0; #1;
    chk("t1_xa0", {bus.o_xarith0_valid, bus.o_xarith0_sel}, 2'b10);
    chk("t1_xl0", {bus.o_xlogic0_valid, bus.o_xlogic0_sel}, 2'b11);
    chk("t1_iss", {bus.o_issue0, bus.o_issue1}, 2'b11);
    step();
    chk("t1_busy", bus.o_busy, 32'h0000_0018);
    bus.i_wb0_valid = 1'b1; bus.i_wb0_rd = 5'd3; bus.i_wb1_valid = 1'b1; bus.i_wb1_rd = 5'd4;
    step(); idle();

    // SHIFT + SHIFT serialises
    set_slot(0, 2, 7, 1, 2, 1'b1); set_slot(1, 2, 8, 1, 2, 1'b1);
    bus.i_input_valid = 1'b1; step();
    bus.i_input_valid = 1'b0; #1;
    chk("t2_first", {bus.o_xshift_valid, bus.o_xshift_sel, bus.o_issue0, bus.o_issue1}, 4'b1010);
    step(); #1;
    chk("t2_second", {bus.o_xshift_valid, bus.o_xshift_sel, bus.o_issue1}, 3'b111);
    step();
    bus.i_wb0_valid = 1'b1; bus.i_wb0_rd = 5'd7; bus.i_wb1_valid = 1'b1; bus.i_wb1_rd = 5'd8;
    step(); idle();

    // RAW on busy[5], released by writeback with no bypass
    set_slot(0, 0, 5, 0, 0, 1'b1); set_slot(1, 3, 0, 0, 0, 1'b0);
    bus.i_input_valid = 1'b1; step();
    bus.i_input_valid = 1'b0; step();
    set_slot(0, 0, 11, 5, 0, 1'b1);
    bus.i_input_valid = 1'b1; step(); #1;
    chk("t3_stall", {bus.o_issue0, bus.o_input_ready}, 2'b00);
    step();
    bus.i_wb0_valid = 1'b1; bus.i_wb0_rd = 5'd5; #1;
    chk("t3_nobypass", bus.o_issue0, 0);
    step();
    bus.i_wb0_valid = 1'b0; bus.i_input_valid = 1'b0; #1;
    chk("t3_release", {bus.o_issue0, bus.o_input_ready}, 2'b11);
    step();
    bus.i_wb0_valid = 1'b1; bus.i_wb0_rd = 5'd11;
    step(); idle();

    // intra-bundle dependency on r9
    set_slot(0, 0, 9, 1, 2, 1'b1); set_slot(1, 0, 12, 9, 0, 1'b1);
    bus.i_input_valid = 1'b1; step();
    bus.i_input_valid = 1'b0; #1;
    chk("t4_alone", {bus.o_issue0, bus.o_issue1, bus.o_xarith0_valid, bus.o_xarith1_valid}, 4'b1010);
    step(); step();
    bus.i_wb0_valid = 1'b1; bus.i_wb0_rd = 5'd9; #1;
    chk("t4_wait", bus.o_issue1, 0);
    step();
    bus.i_wb0_valid = 1'b0; #1;
    chk("t4_go", {bus.o_issue1, bus.o_xarith0_valid, bus.o_xarith0_sel, bus.o_xarith1_valid}, 4'b1110);
    step();
    bus.i_wb0_valid = 1'b1; bus.i_wb0_rd = 5'd12;
    step(); idle();

    // set wins over clear on r10, r0 never busy, paired ARITH
    set_slot(0, 0, 10, 0, 0, 1'b1); set_slot(1, 0, 0, 0, 0, 1'b1);
    bus.i_input_valid = 1'b1; step();
    bus.i_input_valid = 1'b0; bus.i_wb1_valid = 1'b1; bus.i_wb1_rd = 5'd10; #1;
    chk("t5_pair", {bus.o_xarith0_valid, bus.o_xarith0_sel, bus.o_xarith1_valid, bus.o_xarith1_sel}, 4'b1011);
    step();
    chk("t5_busy", bus.o_busy, 32'h0000_0400);
    bus.i_wb1_valid = 1'b0; bus.i_wb0_valid = 1'b1; bus.i_wb0_rd = 5'd10;
    step(); idle();

    // flush in PART beats a presented bundle
    set_slot(0, 2, 13, 1, 2, 1'b1); set_slot(1, 2, 14, 1, 2, 1'b1);
    bus.i_input_valid = 1'b1; step();
    bus.i_input_valid = 1'b0; step();
    set_slot(0, 1, 15, 0, 0, 1'b1); set_slot(1, 3, 0, 0, 0, 1'b0);
    bus.i_input_valid = 1'b1; bus.i_flush = 1'b1; #1;
    chk("t6_flush", {bus.o_input_ready, bus.o_issue1}, 2'b00);
    step();
    bus.i_flush = 1'b0; #1;
    chk("t6_after", {bus.o_input_ready, bus.o_busy}, {1'b1, 32'h0000_2000});
    step();
    bus.i_input_valid = 1'b0; #1;
    chk("t6_new", {bus.o_xlogic0_valid, bus.o_xlogic0_sel}, 2'b10);
    step();
    bus.i_wb0_valid = 1'b1; bus.i_wb0_rd = 5'd13; bus.i_wb1_valid = 1'b1; bus.i_wb1_rd = 5'd15;
    step(); idle();

    // randomized traffic on a narrow register range to provoke hazards
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int c;
      rst_n = (i != 1500);
      bus.i_input_valid = ($urandom_range(0, 9) < 7);
      for (int s = 0; s < 2; s++) begin
        c = $urandom_range(0, 3);
        set_slot(s, c, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 (c != 3) && ($urandom_range(0, 3) != 0));
      end
      bus.i_flush = (m_pend[0] || m_pend[1]) && ($urandom_range(0, 19) == 0);
      bus.i_wb0_valid = $urandom_range(0, 1); bus.i_wb0_rd = 5'($urandom_range(0, 7));
      bus.i_wb1_valid = $urandom_range(0, 1); bus.i_wb1_rd = 5'($urandom_range(0, 7));
      step();
    end
    rst_n = 1'b1; idle(); #1;
`ifdef WARP_ISSUE_STATS_EN
    chk("stat_issued", stat_issued, m_issued);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
